// File: rtl/ctrl_pkg.sv
// ctrl_pkg
// Shared encodings for the multicycle control path: FSM state codes,
// ALUSrcB / ResultSrc mux selects, multiply class codes and the
// instruction Op classes. Imported by main_fsm_ctrl and mul_class_dec,
// and by the ALU decoder that reuses mul_class_dec.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_MULWB  = 4'd10
    } state_t;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] MUL_NONE = 2'b00;
    localparam logic [1:0] MUL_32   = 2'b01;
    localparam logic [1:0] MUL_U64  = 2'b10;
    localparam logic [1:0] MUL_S64  = 2'b11;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

endpackage

// File: rtl/mul_class_dec.sv
// mul_class_dec
// Combinational decode of the multiply class out of the instruction fields.
// Ports:
//   op      in  2  Instr[27:26]
//   funct   in  6  Instr[25:20]
//   mul_nib in  4  Instr[7:4], 4'b1001 marks the multiply class
//   mul_sel out 2  00 none, 01 MUL, 10 UMULL, 11 SMULL
module mul_class_dec (
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic [3:0] mul_nib,
    output logic [1:0] mul_sel
);
    import ctrl_pkg::*;

    // Only the data-processing class with the 1001 nibble is a multiply.
    // Funct[5:3] separates 32-bit MUL from the long forms, and Funct[2]
    // is the signed bit that picks SMULL over UMULL.
    always_comb begin
        mul_sel = MUL_NONE;
        if (op == OP_DP && mul_nib == 4'b1001) begin
            if (funct[5:3] == 3'b000) begin
                mul_sel = MUL_32;
            end else if (funct[5:3] == 3'b001) begin
                mul_sel = funct[2] ? MUL_S64 : MUL_U64;
            end
        end
    end

    // The accumulate / set-flags bits do not affect the class.
    logic unused_funct;
    assign unused_funct = ^funct[1:0];

endmodule

// File: rtl/main_fsm_ctrl.sv
// main_fsm_ctrl
// Multicycle main control FSM. Sequences fetch, decode, load/store,
// data-processing, branch and the multiply forms, producing every
// per-cycle enable and mux select of the datapath. Outputs are decoded
// from the state register; MulSel is captured in DECODE and held until
// the return to FETCH.
// Ports:
//   clk, reset (synchronous, active-high)
//   Op, Funct, MulNib       decoded fields of the latched instruction
//   IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc   datapath controls
//   NextPC, RegW, RegWHi, MemW, Branch, ALUOp, MulSel  qualifiers
//   State                   current state (debug)
// Optional build macro MEM_WAIT_EN adds MemReady / MemFault and memory
// wait states with a WAIT_LIMIT timeout.
module main_fsm_ctrl #(
    parameter int STATE_W    = 4,
    parameter int WAIT_LIMIT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         Op,
    input  logic [5:0]         Funct,
    input  logic [3:0]         MulNib,
`ifdef MEM_WAIT_EN
    input  logic               MemReady,
    output logic               MemFault,
`endif
    output logic               IRWrite,
    output logic               AdrSrc,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ResultSrc,
    output logic               NextPC,
    output logic               RegW,
    output logic               RegWHi,
    output logic               MemW,
    output logic               Branch,
    output logic               ALUOp,
    output logic [1:0]         MulSel,
    output logic [STATE_W-1:0] State
);
    import ctrl_pkg::*;

    state_t     state_q, state_d;
    logic [1:0] mul_dec;
    logic [1:0] mul_sel_q, mul_sel_d;

    mul_class_dec u_mul_class_dec (
        .op      (Op),
        .funct   (Funct),
        .mul_nib (MulNib),
        .mul_sel (mul_dec)
    );

`ifdef MEM_WAIT_EN
    localparam int WAIT_W = $clog2(WAIT_LIMIT + 1);

    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              fault_q, fault_d;
    logic              mem_wait;
    logic              timeout;

    // A memory state that has not seen MemReady is stalling; once it has
    // stalled WAIT_LIMIT cycles the access is abandoned.
    always_comb begin
        mem_wait = (state_q == S_FETCH || state_q == S_MEMRD ||
                    state_q == S_MEMWR) && !MemReady;
        timeout  = mem_wait && (wait_cnt_q == WAIT_W'(WAIT_LIMIT));
    end
`else
    logic unused_wait_limit;
    assign unused_wait_limit = ^WAIT_LIMIT;
`endif

    // State register plus the MulSel capture; everything clears on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_FETCH;
            mul_sel_q  <= MUL_NONE;
`ifdef MEM_WAIT_EN
            wait_cnt_q <= '0;
            fault_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            mul_sel_q  <= mul_sel_d;
`ifdef MEM_WAIT_EN
            wait_cnt_q <= wait_cnt_d;
            fault_q    <= fault_d;
`endif
        end
    end

    // Next-state logic. Long multiplies leave EXECR for MULWB so both
    // halves are written back together; Op = 11 is treated as a no-op.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_BR:   state_d = S_BRANCH;
                    OP_MEM:  state_d = S_MEMADR;
                    OP_DP:   state_d = Funct[5] ? S_EXECI : S_EXECR;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = S_FETCH;
            S_EXECR:  state_d = mul_sel_q[1] ? S_MULWB : S_ALUWB;
            S_EXECI:  state_d = S_ALUWB;
            default:  state_d = S_FETCH;
        endcase
`ifdef MEM_WAIT_EN
        if (mem_wait) begin
            state_d = state_q;
        end
        if (timeout) begin
            state_d = S_FETCH;
        end
`endif
    end

    // MulSel is taken from the decoder while in DECODE and frozen for the
    // rest of the instruction, so EXECR can choose its writeback path.
    always_comb begin
        mul_sel_d = mul_sel_q;
        if (state_q == S_DECODE) begin
            mul_sel_d = mul_dec;
        end
        if (state_d == S_FETCH) begin
            mul_sel_d = MUL_NONE;
        end
    end

`ifdef MEM_WAIT_EN
    // The wait counter only runs while a memory state is stalled and
    // restarts on any state change or after a timeout.
    always_comb begin
        wait_cnt_d = '0;
        fault_d    = fault_q;
        if (mem_wait && !timeout) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
        if (timeout) begin
            fault_d = 1'b1;
        end
    end

    assign MemFault = fault_q;
`endif

    // Moore output decode. With memory waits, the fetch only commits
    // (IR load and PC advance) in the cycle the memory is ready.
    always_comb begin
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SRCB_RD2;
        ResultSrc = RES_ALUOUT;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        RegWHi    = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        ALUOp     = 1'b0;
        case (state_q)
            S_FETCH: begin
`ifdef MEM_WAIT_EN
                IRWrite = MemReady;
                NextPC  = MemReady;
`else
                IRWrite = 1'b1;
                NextPC  = 1'b1;
`endif
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            S_MEMADR: ALUSrcB = SRCB_IMM;
            S_MEMRD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegW      = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
            end
            S_EXECR:  ALUOp = 1'b1;
            S_EXECI: begin
                ALUSrcB = SRCB_IMM;
                ALUOp   = 1'b1;
            end
            S_ALUWB:  RegW = 1'b1;
            S_MULWB: begin
                RegW   = 1'b1;
                RegWHi = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURESULT;
                Branch    = 1'b1;
            end
            default: ;
        endcase
    end

    assign MulSel = (state_q == S_DECODE) ? mul_dec : mul_sel_q;
    assign State  = STATE_W'(state_q);

endmodule

// File: doc/main_fsm_ctrl.md
Name: main_fsm_ctrl

Overview:
- Multicycle control FSM sitting directly upstream of the datapath.
- Consumes the decoded fields of the latched instruction and sequences every per-cycle enable and mux select the datapath needs.
- Covers fetch, decode, load/store, data-processing, branch, MUL and UMULL/SMULL.
- Condition checking and ALUControl decode stay in the surrounding decoder/condlogic; this block supplies their qualifiers (NextPC, RegW, MemW, Branch, ALUOp, MulSel).

Parameters:
- STATE_W, 4, width of the state register and the State debug output.
- WAIT_LIMIT, 15, maximum memory wait cycles before a timeout (only used with MEM_WAIT_EN).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- Op  in  2  Instr[27:26]
- Funct  in  6  Instr[25:20]
- MulNib  in  4  Instr[7:4]; 4'b1001 marks the multiply class
- IRWrite  out  1  load IR
- AdrSrc  out  1  0 = PC, 1 = Result as memory address
- ALUSrcA  out  1  1 = PC, 0 = A
- ALUSrcB  out  2  00 = WriteData, 01 = ExtImm, 10 = constant 4
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- NextPC  out  1  unconditional PC write request
- RegW  out  1  RdLo/Rd write request, gated by condlogic
- RegWHi  out  1  RdHi write request, gated by condlogic
- MemW  out  1  memory write request, gated by condlogic
- Branch  out  1  branch qualifier
- ALUOp  out  1  decoder uses Funct for ALUControl; else ADD
- MulSel  out  2  00 none, 01 MUL, 10 UMULL, 11 SMULL
- State  out  STATE_W  current state (debug)

Behaviour:
- Reset state: FETCH. On reset every output is 0 except the FETCH Moore outputs:
  - IRWrite = 1, NextPC = 1, ALUSrcA = 1, ALUSrcB = 10, ResultSrc = 10, AdrSrc = 0.
- Reset is synchronous, so a mid-instruction reset returns to FETCH on the next edge. No partial write is generated after that edge.
- All outputs are Moore, decoded from the state register only. MulSel is the exception: it is registered in DECODE and held until return to FETCH.
- State encodings 0–10: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, MULWB. Unused codes go to FETCH.
- Transitions:
  - FETCH -> DECODE.
  - DECODE -> BRANCH if Op = 10; MEMADR if Op = 01; otherwise:
    - EXECR if Op = 00 and Funct[5] = 0 (this includes the multiply class);
    - EXECI if Op = 00 and Funct[5] = 1;
    - Op = 11 goes to FETCH (no-op).
  - MEMADR -> MEMRD if Funct[0] = 1 (load), MEMWR otherwise.
  - MEMRD -> MEMWB -> FETCH; MEMWR -> FETCH.
  - EXECR -> MULWB if MulSel is 10 or 11, else ALUWB. EXECI -> ALUWB.
  - ALUWB, MULWB, BRANCH -> FETCH.
- MulSel decode, valid when Op = 00 and MulNib = 1001:
  - Funct[5:3] = 000 gives 01;
  - Funct[5:3] = 001 gives {1, Funct[2]} (U = 0 -> UMULL, S = 1 -> SMULL);
  - otherwise 00.
- Per-state outputs (unlisted outputs are 0):
  - DECODE: ALUSrcA = 1, ALUSrcB = 10, ResultSrc = 10.
  - MEMADR: ALUSrcB = 01.
  - MEMRD: AdrSrc = 1.
  - MEMWB: ResultSrc = 01, RegW = 1.
  - MEMWR: AdrSrc = 1, MemW = 1.
  - EXECR: ALUOp = 1.
  - EXECI: ALUSrcB = 01, ALUOp = 1.
  - ALUWB: RegW = 1.
  - MULWB: RegW = 1, RegWHi = 1, both in the same cycle.
  - BRANCH: ALUSrcB = 01, ResultSrc = 10, Branch = 1.
- Latency in cycles: data-processing 4, MUL 4, UMULL/SMULL 4, LDR 5, STR 4, branch 3.
- No two of RegW, MemW and IRWrite are ever asserted in the same state.

Optional Feature:
- Macro: MEM_WAIT_EN.
- Enabled:
  - Adds input MemReady (1 bit) and output MemFault (1 bit, sticky until reset).
  - FETCH and MEMRD hold while MemReady = 0. IRWrite and NextPC are asserted only in the cycle MemReady = 1.
  - MEMWR holds MemW until MemReady = 1.
  - A wait counter (clog2(WAIT_LIMIT + 1) bits) clears on every state change. When it reaches WAIT_LIMIT, the FSM sets MemFault and goes to FETCH.
- Disabled: memory is assumed single-cycle and the port list is exactly as above.

Decomposition:
- Package ctrl_pkg holds:
  - the state encodings;
  - the ALUSrcB codes (SRCB_RD2, SRCB_IMM, SRCB_FOUR);
  - the ResultSrc codes (RES_ALUOUT, RES_DATA, RES_ALURESULT);
  - the MulSel codes (MUL_NONE, MUL_32, MUL_U64, MUL_S64);
  - OP_DP, OP_MEM, OP_BR.
- One sub-module, mul_class_dec: the combinational decode of Op/Funct/MulNib into MulSel. It is reused by the ALU decoder.

Test Plan:
- Reset asserted for 2 cycles mid-EXECR -> next edge State = FETCH; IRWrite = 1, RegW = 0, MemW = 0.
- LDR (Op = 01, Funct = 011001) -> FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH. RegW = 1 only in MEMWB, with ResultSrc = 01.
- STR (Funct = 011000) -> MEMWR with MemW = 1, AdrSrc = 1; back to FETCH after 4 cycles total.
- ADD immediate (Op = 00, Funct = 101000) -> EXECI with ALUSrcB = 01, ALUOp = 1; then ALUWB with RegW = 1.
- SMULL (Op = 00, Funct = 001100, MulNib = 1001) -> MulSel = 11 from DECODE through MULWB. MULWB has RegW = 1 and RegWHi = 1 in the same cycle. UMULL (Funct = 001000) gives MulSel = 10.
- With MEM_WAIT_EN, MemReady held 0 for 20 cycles in FETCH -> IRWrite stays 0; MemFault = 1 at wait count 15; MemReady = 1 on cycle 3 instead -> DECODE follows.
